mpu_scalar_mul_seq: RTL and testbench
=====================================

Name: mpu_scalar_mul_seq

Overview:
Sequential, parametrised successor to the combinational 5x5 matrix-by-scalar multiplier in the MPU.
- Multiplies a DIM x DIM signed matrix by a signed scalar, LANES elements per clock, under a start/busy/done handshake.
- Supports wrap-around (truncating) or saturating arithmetic and reports overflow.
- Sits between the MPU operand registers and the result writeback stage; trades latency for multiplier count.

Parameters:
- DIM, 5, matrix dimension (DIM x DIM elements, DIM >= 1).
- WIDTH, 8, signed element and factor width in bits (WIDTH >= 2).
- LANES, 1, elements processed per cycle. LANES must divide DIM*DIM; elaboration fails otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- saturate  in  1  mode select: 1 = saturate, 0 = wrap; latched with start.
- factor  in  WIDTH  signed scalar; latched with start.
- matrix_a  in  WIDTH*DIM*DIM  signed input matrix; element k at bits [WIDTH*k +: WIDTH], k = row + DIM*col; latched with start.
- result  out  WIDTH*DIM*DIM  signed output matrix, same packing as matrix_a.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse on completion.
- overflow  out  1  sticky for the current operation; set if any product is out of WIDTH signed range.

Behaviour:
- Reset (async, any state): state=IDLE, result=0, busy=0, done=0, overflow=0, group counter=0, operand latches=0.
- States:
  - IDLE: busy=0. If start=1 at a rising edge: latch matrix_a, factor and saturate; clear result and overflow; counter=0; go to RUN.
  - RUN: busy=1. At each edge, compute elements k = counter*LANES .. counter*LANES+LANES-1 from the latched operands and write them into result; OR their overflow flags into overflow; increment counter.
  - RUN exit: when the last group (counter = K-1, K = DIM*DIM/LANES) is written, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- Latency: start sampled at edge E0, group g written at edge E(g+1), done high during the cycle after edge EK. Minimum start-to-start spacing is K+2 cycles.
- start while busy or in DONE: ignored. Latched operands are unaffected; input changes after E0 have no effect.
- Arithmetic:
  - Full signed product p = factor * element, 2*WIDTH bits.
  - Out of range means p > 2^(WIDTH-1)-1 or p < -2^(WIDTH-1).
  - Wrap mode: result element = p[WIDTH-1:0].
  - Saturate mode: clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - overflow is set on out-of-range in either mode.
- Intermediate result: groups not yet written read 0 during RUN. result holds its final value from done until the next accepted start, which clears it.
- Reset mid-operation: immediate abort to IDLE; no done pulse; all outputs 0.
- Simultaneous rst and start: rst wins.
- Edge cases:
  - factor=0 gives an all-zero result with overflow=0.
  - (-2^(WIDTH-1)) * (-1) is out of range: 127 saturated / -128 wrapped for WIDTH=8, with overflow=1.

Test Plan:
- Defaults, wrap mode, all elements 10, factor 3: done exactly 26 cycles after the start edge, busy high 25 cycles, all elements 30, overflow=0.
- Wrap mode, element 100, factor 2, others 0: that element = -56, overflow=1. Same stimulus in saturate mode: element = 127, overflow=1. Element -100 with factor 2 saturated gives -128.
- Saturate mode, element -128, factor -1 gives 127, overflow=1. Factor 0 on any matrix gives all zeros, overflow=0.
- start pulsed again at cycle 5 of RUN with different operands: ignored, the original result completes, a single done pulse. The next start after IDLE is accepted and clears result.
- rst asserted asynchronously mid-cycle at RUN group 12: busy, done, result and overflow go to 0 without waiting for an edge. No done pulse follows. A new start afterwards completes normally.
- DIM=5, WIDTH=8, LANES=5, factor -2, element k = k-12: done 6 cycles after start, element k = -2*(k-12), overflow=0. A second instance with DIM=4, LANES=3 fails elaboration.

Source files
------------

// File: rtl/mpu_scalar_mul_seq.sv
// Sequential DIM x DIM signed matrix-by-scalar multiplier, LANES elements per clock.
// Wrap or saturate arithmetic, with an overflow flag that stays set for the whole operation.
module mpu_scalar_mul_seq #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     saturate,
  input  logic [WIDTH-1:0]         factor,
  input  logic [WIDTH*DIM*DIM-1:0] matrix_a,
  output logic [WIDTH*DIM*DIM-1:0] result,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int NEL = DIM * DIM;
  localparam int K   = NEL / LANES;
  localparam int CW  = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((NEL % LANES) != 0) begin : g_bad_lanes
    $error("mpu_scalar_mul_seq: LANES must divide DIM*DIM");
  end

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NEL*WIDTH-1:0] mat_q;
  logic [WIDTH-1:0]     fac_q;
  logic                 sat_q;
  logic [NEL*WIDTH-1:0] result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 accept;

  logic [WIDTH-1:0]     elem;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       hi;
  logic                 oor;
  logic [WIDTH-1:0]     val;
  int                   idx;

  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    elem     = '0;
    prod     = '0;
    hi       = '0;
    oor      = 1'b0;
    val      = '0;
    idx      = 0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
        end
      end
      S_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          idx  = int'(cnt_q) * LANES + l;
          elem = mat_q[WIDTH*idx +: WIDTH];
          // Low 2*WIDTH bits of the sign-extended product equal the exact signed product.
          prod = {{WIDTH{fac_q[WIDTH-1]}}, fac_q} * {{WIDTH{elem[WIDTH-1]}}, elem};
          hi   = prod[2*WIDTH-1:WIDTH-1];
          oor  = !(&hi) && (|hi);
          if (oor && sat_q)
            val = prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          else
            val = prod[WIDTH-1:0];
          result_d[WIDTH*idx +: WIDTH] = val;
          ovf_d = ovf_d | oor;
        end
        if (cnt_q == CW'(K - 1))
          state_d = S_DONE;
        else
          cnt_d = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      mat_q    <= '0;
      fac_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      if (accept) begin
        mat_q <= matrix_a;
        fac_q <= factor;
        sat_q <= saturate;
      end
    end
  end

  assign result   = result_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mpu_scalar_mul_seq.sv
// Randomised and directed bench for mpu_scalar_mul_seq against an integer-arithmetic model.
module tb_mpu_scalar_mul_seq;
  localparam int N  = 200;
  localparam int K1 = 25;
  localparam int K5 = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, saturate = 1'b0;
  logic [7:0]   factor = '0;
  logic [N-1:0] matrix_a = '0;
  logic [N-1:0] result;
  logic         busy, done, overflow;

  logic         start2 = 1'b0, saturate2 = 1'b0;
  logic [7:0]   factor2 = '0;
  logic [N-1:0] matrix_b = '0;
  logic [N-1:0] result2;
  logic         busy2, done2, overflow2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mpu_scalar_mul_seq #(.DIM(5), .WIDTH(8), .LANES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .saturate(saturate), .factor(factor),
    .matrix_a(matrix_a), .result(result), .busy(busy), .done(done), .overflow(overflow));

  mpu_scalar_mul_seq #(.DIM(5), .WIDTH(8), .LANES(5)) dut5 (
    .clk(clk), .rst(rst), .start(start2), .saturate(saturate2), .factor(factor2),
    .matrix_a(matrix_b), .result(result2), .busy(busy2), .done(done2), .overflow(overflow2));

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: exact integer product, then clamp or keep the low 8 bits.
  task automatic model(input logic [N-1:0] m, input logic [7:0] f, input logic s, input int upto,
                       output logic [N-1:0] res, output logic ovf);
    int p, e, fi;
    logic [31:0] pu;
    res = '0;
    ovf = 1'b0;
    fi  = int'($signed(f));
    for (int k = 0; k < upto; k++) begin
      e = int'($signed(m[8*k +: 8]));
      p = fi * e;
      if (p > 127 || p < -128) ovf = 1'b1;
      if (s && p > 127)       pu = 32'd127;
      else if (s && p < -128) pu = 32'hFFFF_FF80;
      else                    pu = p;
      res[8*k +: 8] = pu[7:0];
    end
  endtask

  function automatic logic [N-1:0] rand_mat();
    logic [N-1:0] m;
    for (int k = 0; k < 25; k++) m[8*k +: 8] = 8'($urandom);
    return m;
  endfunction

  function automatic logic [N-1:0] fill(input logic [7:0] v);
    logic [N-1:0] m;
    for (int k = 0; k < 25; k++) m[8*k +: 8] = v;
    return m;
  endfunction

  task automatic run_op(input string tag, input logic [N-1:0] m, input logic [7:0] f,
                        input logic s, input bit inject);
    logic [N-1:0] exp_res, part;
    logic exp_ovf, part_ovf;
    int cycles, busy_cnt, extra_done;
    bit seen;
    model(m, f, s, 25, exp_res, exp_ovf);
    model(m, f, s, 4, part, part_ovf);
    @(negedge clk);
    matrix_a = m; factor = f; saturate = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; matrix_a = rand_mat(); factor = ~f; saturate = ~s;
    cycles = 0; busy_cnt = 0; seen = 0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (cycles == 1) check({tag, " cleared"}, result, '0);
      if (busy) busy_cnt++;
      if (cycles == 5) begin
        check({tag, " partial"}, result, part);
        if (inject) begin
          start = 1'b1; matrix_a = rand_mat(); factor = 8'($urandom); saturate = ~s;
        end
      end
      if (done) seen = 1;
    end
    check({tag, " done seen"}, N'(seen), N'(1));
    check({tag, " latency"}, N'(cycles), N'(K1 + 1));
    check({tag, " busy cycles"}, N'(busy_cnt), N'(K1));
    check({tag, " result"}, result, exp_res);
    check({tag, " overflow"}, N'(overflow), N'(exp_ovf));
    @(negedge clk);
    check({tag, " done pulse width"}, N'({done, busy}), N'(0));
    if (inject) begin
      extra_done = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      check({tag, " no second done"}, N'(extra_done), N'(0));
      check({tag, " result held"}, result, exp_res);
    end
  endtask

  initial begin
    logic [N-1:0] m, exp5;
    logic ovf5;
    int cyc, dcount;
    bit seen;

    repeat (2) @(negedge clk);
    check("reset busy/done/ovf", N'({busy, done, overflow}), N'(0));
    check("reset result", result, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", N'({busy, done, overflow}), N'(0));

    run_op("basic 10x3", fill(8'd10), 8'd3, 1'b0, 0);

    m = '0; m[8*7 +: 8] = 8'd100;
    run_op("wrap 100x2", m, 8'd2, 1'b0, 0);
    run_op("sat 100x2", m, 8'd2, 1'b1, 0);
    m = '0; m[8*3 +: 8] = 8'sd156;
    run_op("sat -100x2", m, 8'd2, 1'b1, 0);
    m = '0; m[8*24 +: 8] = 8'h80;
    run_op("sat -128x-1", m, 8'hFF, 1'b1, 0);
    run_op("wrap -128x-1", m, 8'hFF, 1'b0, 0);
    run_op("factor 0", rand_mat(), 8'd0, 1'b1, 0);
    run_op("start ignored", rand_mat(), 8'd5, 1'b0, 1);
    run_op("after ignored", rand_mat(), 8'hFD, 1'b1, 0);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("rand%0d", i), rand_mat(), 8'($urandom), 1'($urandom), 0);

    // Abort mid-run: overflow is already set so the clear is observable.
    @(negedge clk);
    matrix_a = fill(8'd100); factor = 8'd2; saturate = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(negedge clk);
    check("pre-abort busy/ovf", N'({busy, overflow}), N'(2'b11));
    #2 rst = 1'b1;
    #1;
    check("abort flags", N'({busy, done, overflow}), N'(0));
    check("abort result", result, '0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("no done after abort", N'(dcount), N'(0));
    run_op("post-abort", rand_mat(), 8'd7, 1'b1, 0);

    // Five lanes per clock.
    for (int k = 0; k < 25; k++) m[8*k +: 8] = 8'(k - 12);
    model(m, 8'hFE, 1'b0, 25, exp5, ovf5);
    @(negedge clk);
    matrix_b = m; factor2 = 8'hFE; saturate2 = 1'b0; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done2) seen = 1;
    end
    check("lanes5 done seen", N'(seen), N'(1));
    check("lanes5 latency", N'(cyc), N'(K5 + 1));
    check("lanes5 result", result2, exp5);
    check("lanes5 overflow", N'(overflow2), N'(ovf5));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
